// File: rtl/csr_file_if.sv
// CSR access bus between the CSR read-modify-write unit (master) and the
// machine-mode CSR register file (slave).
interface csr_file_if;
  logic [11:0] csr_addr;
  logic        csr_rd_en;
  logic        csr_wr_en;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        illegal_csr;

  modport master (
    output csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
    input  csr_rdata, illegal_csr
  );

  modport slave (
    input  csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
    output csr_rdata, illegal_csr
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR register file for the RV32 core: zero-latency read path,
// trap entry / mret state, and 64-bit mcycle / minstret counters.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  csr_file_if.slave   bus,
  input  logic        instr_retired,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret_en,
  input  logic        irq_ext,
  input  logic        irq_timer,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        irq_pending
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  // Only MEIE (bit 11) and MTIE (bit 7) exist in mie.
  localparam logic [31:0] MIE_MASK    = 32'h0000_0880;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] mip;
  logic        implemented;
  logic        wr_ok;

  assign mip = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};

  // Zero-latency read mux; unimplemented addresses read as 0.
  always_comb begin
    bus.csr_rdata = 32'h0;
    implemented   = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS:               bus.csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q,
                                                3'b0, mstatus_mie_q, 3'b0};
      A_MISA:                  bus.csr_rdata = MISA_VAL;
      A_MIE:                   bus.csr_rdata = mie_q;
      A_MTVEC:                 bus.csr_rdata = mtvec_q;
      A_MSCRATCH:              bus.csr_rdata = mscratch_q;
      A_MEPC:                  bus.csr_rdata = mepc_q;
      A_MCAUSE:                bus.csr_rdata = mcause_q;
      A_MTVAL:                 bus.csr_rdata = mtval_q;
      A_MIP:                   bus.csr_rdata = mip;
      A_MCYCLE,   A_CYCLE:     bus.csr_rdata = mcycle_q[31:0];
      A_MCYCLEH,  A_CYCLEH:    bus.csr_rdata = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:   bus.csr_rdata = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: bus.csr_rdata = minstret_q[63:32];
      A_MHARTID:               bus.csr_rdata = HART_ID;
      default:                 implemented   = 1'b0;
    endcase
  end

  // Address space 0xC00-0xFFF is read-only; writes there are illegal.
  assign bus.illegal_csr = (bus.csr_rd_en | bus.csr_wr_en) &
                           (~implemented | (bus.csr_wr_en & (bus.csr_addr[11:10] == 2'b11)));
  // Trap and mret both take priority over, and drop, a CSR write.
  assign wr_ok = bus.csr_wr_en & ~bus.illegal_csr & ~trap_en & ~mret_en;

  // Next state of trap-related and software-writable CSRs.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap_en) begin
      mepc_d         = trap_pc & ~32'h3;
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_en) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_ok) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = bus.csr_wdata[3];
          mstatus_mpie_d = bus.csr_wdata[7];
        end
        A_MIE:      mie_d      = bus.csr_wdata & MIE_MASK;
        A_MTVEC:    mtvec_d    = bus.csr_wdata & ~32'h3;
        A_MSCRATCH: mscratch_d = bus.csr_wdata;
        A_MEPC:     mepc_d     = bus.csr_wdata & ~32'h3;
        A_MCAUSE:   mcause_d   = bus.csr_wdata;
        A_MTVAL:    mtval_d    = bus.csr_wdata;
        default:    ;
      endcase
    end
  end

  // Counter next state: a write to either half replaces it and skips that cycle's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instr_retired & ~trap_en};
    if (wr_ok) begin
      case (bus.csr_addr)
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], bus.csr_wdata};
        A_MCYCLEH:   mcycle_d   = {bus.csr_wdata, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], bus.csr_wdata};
        A_MINSTRETH: minstret_d = {bus.csr_wdata, minstret_q[31:0]};
        default:     ;
      endcase
    end
  end

  // State registers; reset overrides any trap, mret or write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign irq_pending = mstatus_mie_q & |(mie_q & mip);
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized
// traffic compared against an address-level behavioural model.
module tb_csr_file;
  localparam logic [31:0] P_HART  = 32'd5;
  localparam logic [31:0] P_MISA  = 32'h4000_0100;
  localparam logic [31:0] P_MTVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_retired, trap_en, mret_en, irq_ext, irq_timer;
  logic [31:0] trap_pc, trap_cause, trap_val;
  logic [31:0] mtvec_out, mepc_out;
  logic        irq_pending;

  int n_checks = 0;
  int n_errors = 0;

  csr_file_if bus();

  csr_file #(.HART_ID(P_HART), .MISA_VAL(P_MISA), .RESET_MTVEC(P_MTVEC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .instr_retired(instr_retired), .trap_en(trap_en), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_val(trap_val), .mret_en(mret_en),
    .irq_ext(irq_ext), .irq_timer(irq_timer),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_cycle, m_instret;
  logic        m_ie_bit, m_pie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;

  function automatic bit ref_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
      12'hC82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [11:0] a, input logic rd, input logic wr);
    return (rd || wr) && (!ref_impl(a) || (wr && a >= 12'hC00));
  endfunction

  function automatic logic [31:0] ref_mip();
    return (irq_ext ? 32'h800 : 32'h0) + (irq_timer ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_pie ? 32'h80 : 32'h0) + (m_ie_bit ? 32'h8 : 32'h0);
      12'h301: return P_MISA;
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return ref_mip();
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF14: return P_HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_irq_pending();
    return m_ie_bit && ((m_ie & ref_mip()) != 0);
  endfunction

  // Apply one clock's worth of architectural effect from the current inputs.
  task automatic model_step();
    logic [63:0] nc, ni;
    logic [31:0] wd;
    bit wok;
    wd  = bus.csr_wdata;
    wok = bus.csr_wr_en && !ref_illegal(bus.csr_addr, bus.csr_rd_en, bus.csr_wr_en)
          && !trap_en && !mret_en;
    nc = m_cycle + 1;
    ni = m_instret + ((instr_retired && !trap_en) ? 64'd1 : 64'd0);
    if (wok) begin
      if (bus.csr_addr == 12'hB00) nc = (m_cycle & 64'hFFFF_FFFF_0000_0000) | {32'h0, wd};
      if (bus.csr_addr == 12'hB80) nc = (m_cycle & 64'h0000_0000_FFFF_FFFF) | ({32'h0, wd} << 32);
      if (bus.csr_addr == 12'hB02) ni = (m_instret & 64'hFFFF_FFFF_0000_0000) | {32'h0, wd};
      if (bus.csr_addr == 12'hB82) ni = (m_instret & 64'h0000_0000_FFFF_FFFF) | ({32'h0, wd} << 32);
    end
    if (!reset_n) begin
      m_cycle = 0; m_instret = 0; m_ie_bit = 0; m_pie = 0; m_ie = 0;
      m_tvec = P_MTVEC; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    end else begin
      m_cycle = nc; m_instret = ni;
      if (trap_en) begin
        m_epc = trap_pc - (trap_pc % 4); m_cause = trap_cause; m_tval = trap_val;
        m_pie = m_ie_bit; m_ie_bit = 0;
      end else if (mret_en) begin
        m_ie_bit = m_pie; m_pie = 1;
      end else if (wok) begin
        case (bus.csr_addr)
          12'h300: begin m_ie_bit = wd[3]; m_pie = wd[7]; end
          12'h304: m_ie = wd & 32'h880;
          12'h305: m_tvec = wd - (wd % 4);
          12'h340: m_scratch = wd;
          12'h341: m_epc = wd - (wd % 4);
          12'h342: m_cause = wd;
          12'h343: m_tval = wd;
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_rd_en = 0; bus.csr_wr_en = 0; bus.csr_wdata = 0; bus.csr_addr = 12'h000;
    instr_retired = 0; trap_en = 0; mret_en = 0;
    trap_pc = 0; trap_cause = 0; trap_val = 0;
  endtask

  task automatic acc(input logic [11:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    idle();
    bus.csr_addr = a; bus.csr_rd_en = rd; bus.csr_wr_en = wr; bus.csr_wdata = wd;
  endtask

  task automatic do_reset();
    idle(); reset_n = 0; tick(); reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; irq_ext = 0; irq_timer = 0;
    acc(12'h305, 1'b0, 1'b1, 32'hFFFF_FFF0);
    tick(); tick();
    reset_n = 1;
    acc(12'hB00, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_mcycle0 got=%h exp=%h", bus.csr_rdata, 32'd0); end
    tick();
    n_checks++; if (bus.csr_rdata !== 32'd1) begin n_errors++; $display("FAIL reset_mcycle1 got=%h exp=%h", bus.csr_rdata, 32'd1); end
    acc(12'h305, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== P_MTVEC) begin n_errors++; $display("FAIL reset_mtvec got=%h exp=%h", bus.csr_rdata, P_MTVEC); end
    n_checks++; if (mtvec_out !== P_MTVEC) begin n_errors++; $display("FAIL reset_mtvec_out got=%h exp=%h", mtvec_out, P_MTVEC); end
    n_checks++; if (mepc_out !== 32'h0 || irq_pending !== 1'b0) begin n_errors++; $display("FAIL reset_outs mepc=%h irq=%b exp 0/0", mepc_out, irq_pending); end
    acc(12'hF14, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== P_HART) begin n_errors++; $display("FAIL reset_hartid got=%h exp=%h", bus.csr_rdata, P_HART); end
    acc(12'h301, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== P_MISA) begin n_errors++; $display("FAIL reset_misa got=%h exp=%h", bus.csr_rdata, P_MISA); end
  endtask

  task automatic test_mtvec();
    acc(12'h305, 1'b0, 1'b1, 32'h8000_0003); tick();
    acc(12'h305, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h8000_0000) begin n_errors++; $display("FAIL mtvec_read got=%h exp=%h", bus.csr_rdata, 32'h8000_0000); end
    n_checks++; if (mtvec_out !== 32'h8000_0000) begin n_errors++; $display("FAIL mtvec_out got=%h exp=%h", mtvec_out, 32'h8000_0000); end
  endtask

  task automatic test_trap_mret();
    acc(12'h300, 1'b0, 1'b1, 32'h8); tick();
    acc(12'h304, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
    acc(12'h304, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h880) begin n_errors++; $display("FAIL mie_mask got=%h exp=%h", bus.csr_rdata, 32'h880); end
    acc(12'h304, 1'b0, 1'b1, 32'h800); tick();
    idle(); irq_ext = 1; #1;
    n_checks++; if (irq_pending !== 1'b1) begin n_errors++; $display("FAIL irq_pending_set got=%b exp=1", irq_pending); end
    idle(); trap_en = 1; trap_pc = 32'h104; trap_cause = 32'h8000_000B; trap_val = 32'h55; tick();
    acc(12'h341, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h104 || mepc_out !== 32'h104) begin n_errors++; $display("FAIL trap_mepc got=%h/%h exp=%h", bus.csr_rdata, mepc_out, 32'h104); end
    acc(12'h342, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h8000_000B) begin n_errors++; $display("FAIL trap_mcause got=%h exp=%h", bus.csr_rdata, 32'h8000_000B); end
    acc(12'h343, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h55) begin n_errors++; $display("FAIL trap_mtval got=%h exp=%h", bus.csr_rdata, 32'h55); end
    acc(12'h300, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h1880) begin n_errors++; $display("FAIL trap_mstatus got=%h exp=%h", bus.csr_rdata, 32'h1880); end
    n_checks++; if (irq_pending !== 1'b0) begin n_errors++; $display("FAIL trap_irq_pending got=%b exp=0", irq_pending); end
    idle(); mret_en = 1; tick();
    acc(12'h300, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h1888) begin n_errors++; $display("FAIL mret_mstatus got=%h exp=%h", bus.csr_rdata, 32'h1888); end
    n_checks++; if (irq_pending !== 1'b1) begin n_errors++; $display("FAIL mret_irq_pending got=%b exp=1", irq_pending); end
    irq_ext = 0; #1;
    n_checks++; if (irq_pending !== 1'b0) begin n_errors++; $display("FAIL irq_drop got=%b exp=0", irq_pending); end
  endtask

  task automatic test_counter_wrap();
    acc(12'hB00, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
    acc(12'hB80, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
    acc(12'hB00, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_lo_held got=%h exp=%h", bus.csr_rdata, 32'hFFFF_FFFF); end
    acc(12'hB80, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_hi_held got=%h exp=%h", bus.csr_rdata, 32'hFFFF_FFFF); end
    tick();
    n_checks++; if (bus.csr_rdata !== 32'h0) begin n_errors++; $display("FAIL wrap_hi_zero got=%h exp=%h", bus.csr_rdata, 32'h0); end
    acc(12'hC00, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h0) begin n_errors++; $display("FAIL wrap_lo_zero got=%h exp=%h", bus.csr_rdata, 32'h0); end
    tick();
    n_checks++; if (bus.csr_rdata !== 32'h1) begin n_errors++; $display("FAIL wrap_lo_one got=%h exp=%h", bus.csr_rdata, 32'h1); end
  endtask

  task automatic test_illegal();
    acc(12'hF14, 1'b0, 1'b1, 32'h99); #1;
    n_checks++; if (bus.illegal_csr !== 1'b1) begin n_errors++; $display("FAIL ill_hartid_wr got=%b exp=1", bus.illegal_csr); end
    tick();
    acc(12'hF14, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== P_HART || bus.illegal_csr !== 1'b0) begin n_errors++; $display("FAIL ill_hartid_keep got=%h/%b exp=%h/0", bus.csr_rdata, bus.illegal_csr, P_HART); end
    acc(12'hC00, 1'b0, 1'b1, 32'hFFFF_FFF0); #1;
    n_checks++; if (bus.illegal_csr !== 1'b1) begin n_errors++; $display("FAIL ill_cycle_wr got=%b exp=1", bus.illegal_csr); end
    tick();
    acc(12'hB00, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== m_cycle[31:0]) begin n_errors++; $display("FAIL ill_cycle_keep got=%h exp=%h", bus.csr_rdata, m_cycle[31:0]); end
    acc(12'h7C0, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.illegal_csr !== 1'b1 || bus.csr_rdata !== 32'h0) begin n_errors++; $display("FAIL ill_unimpl got=%b/%h exp=1/0", bus.illegal_csr, bus.csr_rdata); end
    acc(12'h7C0, 1'b0, 1'b0, 32'h0); #1;
    n_checks++; if (bus.illegal_csr !== 1'b0) begin n_errors++; $display("FAIL ill_noaccess got=%b exp=0", bus.illegal_csr); end
    acc(12'h301, 1'b1, 1'b1, 32'h0); #1;
    n_checks++; if (bus.illegal_csr !== 1'b0) begin n_errors++; $display("FAIL misa_wr_legal got=%b exp=0", bus.illegal_csr); end
    tick();
    acc(12'h301, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== P_MISA) begin n_errors++; $display("FAIL misa_ro got=%h exp=%h", bus.csr_rdata, P_MISA); end
  endtask

  task automatic test_trap_priority();
    do_reset();
    acc(12'h340, 1'b0, 1'b1, 32'hAA); tick();
    acc(12'h340, 1'b0, 1'b1, 32'h1234);
    trap_en = 1; trap_pc = 32'h207; trap_cause = 32'h2; trap_val = 32'h9; instr_retired = 1;
    tick();
    acc(12'h340, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'hAA) begin n_errors++; $display("FAIL prio_mscratch got=%h exp=%h", bus.csr_rdata, 32'hAA); end
    n_checks++; if (mepc_out !== 32'h204) begin n_errors++; $display("FAIL prio_mepc got=%h exp=%h", mepc_out, 32'h204); end
    acc(12'hB02, 1'b1, 1'b0, 32'h0); #1;
    n_checks++; if (bus.csr_rdata !== 32'h0) begin n_errors++; $display("FAIL prio_minstret got=%h exp=%h", bus.csr_rdata, 32'h0); end
    instr_retired = 1; tick();
    n_checks++; if (bus.csr_rdata !== 32'h1) begin n_errors++; $display("FAIL retire_inc got=%h exp=%h", bus.csr_rdata, 32'h1); end
    acc(12'h341, 1'b0, 1'b1, 32'h0000_1000); mret_en = 1; tick();
    n_checks++; if (mepc_out !== 32'h204) begin n_errors++; $display("FAIL mret_drops_wr got=%h exp=%h", mepc_out, 32'h204); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                12'h7C0, 12'h000, 12'h3A0, 12'hB03};
    for (int i = 0; i < 500; i++) begin
      reset_n            = ($urandom_range(0, 99) >= 2);
      bus.csr_addr       = addrs[$urandom_range(0, 21)];
      bus.csr_rd_en      = ($urandom_range(0, 99) < 60);
      bus.csr_wr_en      = ($urandom_range(0, 99) < 40);
      bus.csr_wdata      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      instr_retired      = $urandom_range(0, 1);
      trap_en            = ($urandom_range(0, 99) < 6);
      mret_en            = ($urandom_range(0, 99) < 6);
      trap_pc            = $urandom;
      trap_cause         = $urandom;
      trap_val           = $urandom;
      irq_ext            = $urandom_range(0, 1);
      irq_timer          = $urandom_range(0, 1);
      #1;
      n_checks++; if (bus.csr_rdata !== ref_read(bus.csr_addr)) begin n_errors++; $display("FAIL rand_rdata i=%0d addr=%h got=%h exp=%h", i, bus.csr_addr, bus.csr_rdata, ref_read(bus.csr_addr)); end
      n_checks++; if (bus.illegal_csr !== ref_illegal(bus.csr_addr, bus.csr_rd_en, bus.csr_wr_en)) begin n_errors++; $display("FAIL rand_illegal i=%0d addr=%h got=%b exp=%b", i, bus.csr_addr, bus.illegal_csr, ref_illegal(bus.csr_addr, bus.csr_rd_en, bus.csr_wr_en)); end
      n_checks++; if (mtvec_out !== m_tvec) begin n_errors++; $display("FAIL rand_mtvec i=%0d got=%h exp=%h", i, mtvec_out, m_tvec); end
      n_checks++; if (mepc_out !== m_epc) begin n_errors++; $display("FAIL rand_mepc i=%0d got=%h exp=%h", i, mepc_out, m_epc); end
      n_checks++; if (irq_pending !== ref_irq_pending()) begin n_errors++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq_pending, ref_irq_pending()); end
      tick();
    end
    reset_n = 1; idle(); irq_ext = 0; irq_timer = 0;
  endtask

  initial begin
    reset_n = 0; irq_ext = 0; irq_timer = 0;
    idle();
    test_reset();
    test_mtvec();
    test_trap_mret();
    test_counter_wrap();
    test_illegal();
    test_trap_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32 core datapath.
- Sits directly downstream of the CSR read-modify-write unit: it consumes that unit's computed write value and returns the current CSR value, which the unit uses as its old-value input.
- Also owns trap entry/return state (mstatus/mepc/mcause/mtval) and the 64-bit cycle and instret counters.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 32'h40000100, read-only misa value (RV32I).
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- csr_addr  in  12  CSR address from instruction bits 31:20.
- csr_rd_en  in  1  instruction reads the CSR.
- csr_wr_en  in  1  instruction writes the CSR; driven low for csrrs/csrrc with rs1=x0.
- csr_wdata  in  32  final write value from the CSR modify unit.
- csr_rdata  out  32  current CSR value; combinational.
- illegal_csr  out  1  access is illegal; combinational.
- instr_retired  in  1  one instruction retires this cycle.
- trap_en  in  1  take a trap this cycle.
- trap_pc  in  32  PC of the trapping instruction.
- trap_cause  in  32  mcause value.
- trap_val  in  32  mtval value.
- mret_en  in  1  mret executes this cycle.
- irq_ext, irq_timer  in  1 each  level interrupt inputs, reflected in mip.
- mtvec_out  out  32  trap vector base.
- mepc_out  out  32  return address for mret.
- irq_pending  out  1  mstatus.MIE & |(mie & mip).

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301.
  - mie 0x304: bits 11 and 7 writable, all others 0.
  - mtvec 0x305: bits 1:0 forced 00.
  - mscratch 0x340.
  - mepc 0x341: bits 1:0 forced 00.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; bit11=irq_ext, bit7=irq_timer.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: read-only aliases.
  - mhartid 0xF14: read-only.
- Read path: csr_rdata is valid in the same cycle as csr_addr (zero latency). It equals 0 when the address is unimplemented.
- illegal_csr = (csr_rd_en|csr_wr_en) & (address unimplemented | (csr_wr_en & csr_addr[11:10]==2'b11)).
  - When illegal_csr is high, no CSR state changes from the access.
- Write: takes effect at the rising edge, visible on csr_rdata the next cycle. Writes to read-only bits are ignored.
- Counters: 64-bit, wrap 2^64-1 -> 0.
  - mcycle increments every cycle.
  - minstret increments when instr_retired=1 and trap_en=0.
  - A CSR write to any half of a counter replaces that half and suppresses that counter's increment that cycle, so the written value is read back exactly.
- Trap entry (trap_en=1), at the edge:
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - mtval <= trap_val.
  - MPIE <= MIE, then MIE <= 0.
- mret (mret_en=1): MIE <= MPIE, MPIE <= 1.
- Priority, highest first: trap_en > mret_en > CSR write.
  - A CSR write in a trap or mret cycle is dropped.
  - Counter increments are independent of this priority, apart from the minstret rule above.
- Reset (reset_n=0 at edge): all writable CSRs and counters <= 0, except mtvec <= RESET_MTVEC.
  - Reset overrides any write, trap or mret in the same cycle.
  - Reset mid-operation discards pending state.
- Output reset values: mtvec_out=RESET_MTVEC, mepc_out=0, irq_pending=0.
  - csr_rdata and illegal_csr follow the combinational rules above.

Test Plan:
- Reset, then read 0xB00 on two consecutive cycles -> 0 then 1. Read 0x305 -> RESET_MTVEC. Read 0xF14 -> HART_ID.
- Write 0x305 with 0x8000_0003 -> next-cycle read 0x8000_0000; mtvec_out=0x8000_0000.
- Write 0x300 with 0x8, set mie=0x800, raise irq_ext -> irq_pending=1. Then trap_en with trap_pc=0x104, cause=0x8000000B:
  - mepc=0x104, mcause=0x8000000B.
  - mstatus reads 0x1880; irq_pending=0.
  - mret -> mstatus reads 0x1888.
- Write 0xB00=0xFFFF_FFFF and 0xB80=0xFFFF_FFFF, then idle -> mcycle wraps to 0 (mcycleh=0) two cycles after the last write.
- Write 0xC00 or 0xF14 with csr_wr_en=1, or read 0x7C0 -> illegal_csr=1, state unchanged.
- trap_en and csr_wr_en to 0x340 (value 0x1234) in the same cycle -> mscratch unchanged; trap state updated. instr_retired=1 with trap_en=1 -> minstret unchanged.
